bus_memory_responder: RTL and testbench
=======================================

Name: bus_memory_responder

Overview:
- Responder end of the CPU memory bus (we/addr/data/out): a 64x16 synchronous RAM that answers CPU reads and writes.
- Adds a host image-load port with a valid/ready handshake, which replaces the file-based init.
- Adds a clear-on-reset sweep. A busy flag holds the CPU off while the RAM is owned by the sweep or the loader.
- Sits beside the cpu in the top level and in the bench, in place of the plain memory model.

Parameters:
ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 16, word width
CLEAR_ON_RESET, 1, 1 = zero the whole RAM after reset; 0 = skip straight to IDLE

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
we  input  1  CPU write enable
addr  input  ADDR_WIDTH  CPU word address
data  input  DATA_WIDTH  CPU write data
out  output  DATA_WIDTH  CPU read data, registered
busy  output  1  RAM owned by clear/load; CPU must hold in reset or stall
ld_start  input  1  one-cycle pulse: begin image load at address 0
ld_valid  input  1  host word valid
ld_data  input  DATA_WIDTH  host word
ld_ready  output  1  responder accepts ld_data this cycle
ld_done  output  1  one-cycle pulse: load finished
ld_count  output  ADDR_WIDTH+1  words written by the current/last load

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: out=0, ld_ready=0, ld_done=0, ld_count=0, ptr=0.
  - State after reset is CLEAR (busy=1) if CLEAR_ON_RESET=1, else IDLE (busy=0).
- FSM states: CLEAR, IDLE, LOAD.
- CLEAR:
  - Writes 0 to mem[ptr] each cycle; ptr increments.
  - After writing DEPTH-1 (DEPTH cycles total), go to IDLE with ptr=0.
  - busy=1 throughout; CPU we ignored; out=0; ld_start ignored.
- IDLE:
  - busy=0.
  - CPU writes: we=1 writes data to mem[addr] at the edge.
  - CPU reads: out <= mem[addr] every cycle, one-cycle latency.
  - Same-cycle write and read to the same addr is read-first: out shows the old word and the new word is visible the next cycle.
  - ld_start=1 moves to LOAD with ptr=0 and ld_count=0. If we=1 in that same cycle, the CPU write is still performed.
- LOAD:
  - busy=1; ld_ready=1.
  - Each cycle with ld_valid=1 (ld_valid && ld_ready) writes ld_data to mem[ptr]; ptr and ld_count increment.
  - Cycles with ld_valid=0 stall with no state change.
  - Exit after the word written to DEPTH-1, i.e. ld_count reaches DEPTH: pulse ld_done for one cycle, return to IDLE with ld_ready=0.
  - ld_start is ignored while in LOAD. There is no wrap and no overwrite of address 0.
  - CPU we is ignored; out is held at 0.
- ptr is internal: ADDR_WIDTH bits, wraps naturally. Termination is by ld_count / cycle count, never by ptr wrap.
- Reset mid-CLEAR or mid-LOAD:
  - Abandons the operation; no ld_done pulse.
  - RAM contents are not rolled back; CLEAR restarts if enabled.
- ld_count holds its final value in IDLE until the next ld_start.
- Reads of a never-written address with CLEAR_ON_RESET=0 return X in simulation; the bench must not rely on them.

Decomposition:
- Shared package bus_mem_pkg holds:
  - state enum (CLEAR, IDLE, LOAD)
  - default ADDR_WIDTH/DATA_WIDTH localparams
  - the read-first policy constant
- One natural sub-module: sp_ram_rf, a single-port read-first synchronous RAM (we, addr, wdata, rdata).
  - The FSM muxes address, we and wdata between CPU, clear and load sources.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy=1 for exactly 64 cycles then 0; afterwards reading addr 0, 31, 63 each returns 0x0000 one cycle after the address is applied.
- IDLE, write addr=5 data=0xBEEF, next cycle read addr=5 -> out=0xBEEF one cycle later. Same-cycle write 0x1234 and read of addr 5 -> out=0xBEEF, then 0x1234 the next cycle.
- ld_start, then 64 words 0x0100+i with ld_valid toggling 1/0 every cycle -> 128 LOAD cycles, single ld_done pulse, ld_count=64, busy drops with it; mem[i]=0x0100+i for all i.
- During LOAD drive we=1 addr=3 data=0xFFFF -> mem[3] keeps its loaded value 0x0103.
- Assert rst after 10 loaded words -> no ld_done, ld_count=0, CLEAR sweep restarts; after it completes, mem[2]=0x0000.
- ld_start pulsed while in LOAD -> ignored; ld_count continues without restart and still ends at 64.

Source files
------------

// File: rtl/bus_mem_pkg.sv
// Shared types and defaults for the CPU-bus memory responder.
package bus_mem_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 6;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  // Same-cycle write and read of one address returns the old word.
  localparam bit READ_FIRST = 1'b1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/sp_ram_rf.sv
// Single-port synchronous RAM with registered read data.
module sp_ram_rf
  import bus_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit          RD_FIRST   = READ_FIRST
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port plus registered read; the policy picks old or new word on a collision.
  // NOTE: the array has no reset so it maps onto a RAM macro; clearing is done by the owner.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (RD_FIRST || !we) begin
      rdata <= mem[addr];
    end else begin
      rdata <= wdata;
    end
  end

endmodule

// File: rtl/bus_memory_responder.sv
// Responder end of the CPU memory bus: 64x16 RAM with clear-on-reset
// sweep and a host image-load port that owns the RAM while busy.
module bus_memory_responder
  import bus_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic [ADDR_WIDTH:0]   ld_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LAST_COUNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt;
  logic [ADDR_WIDTH:0]     count_nxt;
  logic                    done_nxt;
  logic                    out_en;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  // State, pointer, load counter and output-enable registers.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr      <= '0;
      ld_count <= '0;
      ld_done  <= 1'b0;
      out_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      ld_count <= count_nxt;
      ld_done  <= done_nxt;
      // Read data is only meaningful for a read issued while the CPU owns the RAM.
      out_en   <= (state == ST_IDLE);
    end
  end

  // Next-state logic and RAM port mux between CPU, clear sweep and loader.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    count_nxt = ld_count;
    done_nxt  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr;
    ram_wdata = data;
    unique case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = ptr;
        ram_wdata = '0;
        ptr_nxt   = ptr + 1'b1;
        // ptr doubles as the sweep cycle count; it lands back on 0 here.
        if (ptr == LAST_ADDR) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ram_we = we;
        if (ld_start) begin
          state_nxt = ST_LOAD;
          ptr_nxt   = '0;
          count_nxt = '0;
        end
      end
      ST_LOAD: begin
        ram_addr  = ptr;
        ram_wdata = ld_data;
        ram_we    = ld_valid;
        if (ld_valid) begin
          ptr_nxt   = ptr + 1'b1;
          count_nxt = ld_count + 1'b1;
          if (ld_count == LAST_COUNT) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sp_ram_rf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RD_FIRST   (READ_FIRST)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign busy     = (state != ST_IDLE);
  assign ld_ready = (state == ST_LOAD);
  assign out      = out_en ? ram_rdata : '0;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Randomised scoreboard bench for bus_memory_responder against an
// array model of the RAM contents.
module tb_bus_memory_responder;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [DW-1:0] out;
  logic          busy;
  logic          ld_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic [AW:0]   ld_count;

  always #5 clk = ~clk;

  bus_memory_responder #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .data     (data),
    .out      (out),
    .busy     (busy),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_count (ld_count)
  );

  typedef struct {
    int          due;
    logic [DW-1:0] exp;
    logic [AW-1:0] a;
  } rd_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  rd_t           sb[$];
  rd_t           mon_e;
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one cycle after a read is issued, compare out with the queued word.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      check($sformatf("read_addr_%0d", mon_e.a), 32'(out), 32'(mon_e.exp));
    end
  end

  // One IDLE bus cycle: the model answers read-first, then applies the write.
  task automatic idle_op(bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    rd_t e;
    we   = w;
    addr = a;
    data = d;
    e.due = cyc + 1;
    e.exp = ref_mem[a];
    e.a   = a;
    sb.push_back(e);
    if (w) ref_mem[a] = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) idle_op(1'b0, AW'(a), '0);
  endtask

  // Reset, then expect a DEPTH-cycle busy sweep that zeroes the RAM.
  task automatic reset_and_clear();
    int n = 0;
    int done_seen = 0;
    rst = 1'b1; we = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_ld_count", 32'(ld_count), 32'd0);
    check("reset_ld_done", 32'(ld_done), 32'd0);
    check("reset_ld_ready", 32'(ld_ready), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    while (busy === 1'b1 && n < 200) begin
      if (ld_done !== 1'b0) done_seen++;
      if (n == 10) check("clear_out_zero", 32'(out), 32'd0);
      we = 1'b1; addr = AW'($urandom); data = 16'hFFFF;
      ld_start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n++;
    end
    we = 1'b0; ld_start = 1'b0;
    check("clear_busy_cycles", 32'(n), 32'd64);
    check("clear_no_ld_done", 32'(done_seen), 32'd0);
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
  endtask

  // mode 0: valid toggles 0/1, data 0x0100+i, CPU writes 0xFFFF to addr 3.
  // mode 1: random valid, data, CPU traffic and stray ld_start pulses.
  // stop_after >= 0 returns mid-load after that many accepted words.
  task automatic do_load(int mode, int stop_after);
    int n_acc = 0;
    int n_cyc = 0;
    int bad_ready = 0, bad_busy = 0, bad_done = 0, bad_out = 0;
    bit v;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    while (n_acc < DEPTH && n_cyc < 2000) begin
      if (stop_after >= 0 && n_acc == stop_after) return;
      if (ld_ready !== 1'b1) bad_ready++;
      if (busy !== 1'b1) bad_busy++;
      if (ld_done !== 1'b0) bad_done++;
      if (n_cyc > 0 && out !== '0) bad_out++;
      if (mode == 0) begin
        v        = (n_cyc % 2 == 1);
        ld_data  = DW'(32'h0100 + n_acc);
        we       = 1'b1;
        addr     = AW'(3);
        data     = 16'hFFFF;
        ld_start = (n_cyc == 40);
      end else begin
        v        = ($urandom_range(0, 2) != 0);
        ld_data  = DW'($urandom);
        we       = $urandom_range(0, 1) == 1;
        addr     = AW'($urandom);
        data     = DW'($urandom);
        ld_start = ($urandom_range(0, 5) == 0);
      end
      ld_valid = v;
      if (v) begin
        ref_mem[n_acc] = ld_data;
        n_acc++;
      end
      @(negedge clk);
      n_cyc++;
    end
    ld_valid = 1'b0; we = 1'b0; ld_start = 1'b0;
    check("load_ready_high", 32'(bad_ready), 32'd0);
    check("load_busy_high", 32'(bad_busy), 32'd0);
    check("load_no_early_done", 32'(bad_done), 32'd0);
    check("load_out_zero", 32'(bad_out), 32'd0);
    if (mode == 0) check("load_cycles", 32'(n_cyc), 32'd128);
    check("load_done_pulse", 32'(ld_done), 32'd1);
    check("load_busy_drop", 32'(busy), 32'd0);
    check("load_ready_drop", 32'(ld_ready), 32'd0);
    check("load_count", 32'(ld_count), 32'd64);
    @(negedge clk);
    check("load_done_single", 32'(ld_done), 32'd0);
    check("load_count_hold", 32'(ld_count), 32'd64);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; data = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    @(negedge clk);

    // Power-on sweep, then spot reads of the cleared RAM.
    reset_and_clear();
    idle_op(1'b0, AW'(0), '0);
    idle_op(1'b0, AW'(31), '0);
    idle_op(1'b0, AW'(63), '0);

    // Write/read and read-first collision on addr 5.
    idle_op(1'b1, AW'(5), 16'hBEEF);
    idle_op(1'b0, AW'(5), '0);
    idle_op(1'b1, AW'(5), 16'h1234);
    idle_op(1'b0, AW'(5), '0);

    // Directed image load with gaps, blocked CPU writes and a stray ld_start.
    do_load(0, -1);
    read_all();

    // Reset partway through a load.
    do_load(1, 10);
    reset_and_clear();
    idle_op(1'b0, AW'(2), '0);

    // Random CPU traffic on a small address window to force collisions.
    for (int i = 0; i < 300; i++) begin
      idle_op($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), DW'($urandom));
    end
    read_all();

    // Random image load, then full readback.
    do_load(1, -1);
    read_all();
    for (int i = 0; i < 100; i++) begin
      idle_op($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
